// File: rtl/counter_sequencer.sv
// Burst sequencer that drives a counter's enable: a configurable number of
// bursts, each holding enable high for run_len cycles, separated by pause_len
// low cycles, with abort, reject and completion status pulses.
module counter_sequencer #(
  parameter int LEN_BITWIDTH   = 8,
  parameter int BURST_BITWIDTH = 4
) (
  input  logic                      clock_i,
  input  logic                      reset_i,
  input  logic                      start_i,
  input  logic                      abort_i,
  input  logic [LEN_BITWIDTH-1:0]   run_len_i,
  input  logic [LEN_BITWIDTH-1:0]   pause_len_i,
  input  logic [BURST_BITWIDTH-1:0] bursts_i,
  output logic                      enable_o,
  output logic                      busy_o,
  output logic                      done_o,
  output logic                      aborted_o,
  output logic                      error_o,
  output logic [BURST_BITWIDTH-1:0] burst_cnt_o
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [LEN_BITWIDTH-1:0]   LEN_ZERO   = {LEN_BITWIDTH{1'b0}};
  localparam logic [LEN_BITWIDTH-1:0]   LEN_ONE    = {{(LEN_BITWIDTH-1){1'b0}}, 1'b1};
  localparam logic [BURST_BITWIDTH-1:0] BURST_ZERO = {BURST_BITWIDTH{1'b0}};
  localparam logic [BURST_BITWIDTH-1:0] BURST_ONE  = {{(BURST_BITWIDTH-1){1'b0}}, 1'b1};

  state_t                    state_r,     state_s;
  logic [LEN_BITWIDTH-1:0]   run_len_r,   run_len_s;
  logic [LEN_BITWIDTH-1:0]   pause_len_r, pause_len_s;
  logic [BURST_BITWIDTH-1:0] bursts_r,    bursts_s;
  logic [LEN_BITWIDTH-1:0]   cyc_cnt_r,   cyc_cnt_s;
  logic [BURST_BITWIDTH-1:0] burst_cnt_r, burst_cnt_s;
  logic                      enable_r,    enable_s;
  logic                      busy_r;
  logic                      done_r,      done_s;
  logic                      aborted_r,   aborted_s;
  logic                      error_r,     error_s;
  logic [BURST_BITWIDTH-1:0] burst_inc_s;

  // Count of completed bursts once the current burst finishes.
  always_comb begin
    burst_inc_s = burst_cnt_r + BURST_ONE;
  end

  // Next-state and next-output decode. cyc_cnt_r holds the 1-based index of
  // the current enabled (RUN) or idle (PAUSE) cycle, so it never exceeds the
  // programmed length and cannot wrap. RUN with enable_r low only happens in
  // the single latency cycle right after a start is accepted.
  always_comb begin
    state_s     = state_r;
    run_len_s   = run_len_r;
    pause_len_s = pause_len_r;
    bursts_s    = bursts_r;
    cyc_cnt_s   = cyc_cnt_r;
    burst_cnt_s = burst_cnt_r;
    enable_s    = enable_r;
    done_s      = 1'b0;
    aborted_s   = 1'b0;
    error_s     = 1'b0;
    case (state_r)
      IDLE: begin
        enable_s = 1'b0;
        if (start_i && !abort_i) begin
          if ((run_len_i != LEN_ZERO) && (bursts_i != BURST_ZERO)) begin
            run_len_s   = run_len_i;
            pause_len_s = pause_len_i;
            bursts_s    = bursts_i;
            burst_cnt_s = BURST_ZERO;
            cyc_cnt_s   = LEN_ZERO;
            state_s     = RUN;
          end else begin
            error_s = 1'b1;
          end
        end else begin
          state_s = IDLE;
        end
      end
      RUN: begin
        if (abort_i) begin
          state_s   = IDLE;
          enable_s  = 1'b0;
          aborted_s = 1'b1;
        end else if (!enable_r) begin
          enable_s  = 1'b1;
          cyc_cnt_s = LEN_ONE;
        end else if (cyc_cnt_r == run_len_r) begin
          burst_cnt_s = burst_inc_s;
          cyc_cnt_s   = LEN_ONE;
          if (burst_inc_s == bursts_r) begin
            state_s  = DONE;
            enable_s = 1'b0;
            done_s   = 1'b1;
          end else if (pause_len_r != LEN_ZERO) begin
            state_s  = PAUSE;
            enable_s = 1'b0;
          end else begin
            state_s  = RUN;
            enable_s = 1'b1;
          end
        end else begin
          cyc_cnt_s = cyc_cnt_r + LEN_ONE;
          enable_s  = 1'b1;
        end
      end
      PAUSE: begin
        if (abort_i) begin
          state_s   = IDLE;
          enable_s  = 1'b0;
          aborted_s = 1'b1;
        end else if (cyc_cnt_r == pause_len_r) begin
          state_s   = RUN;
          enable_s  = 1'b1;
          cyc_cnt_s = LEN_ONE;
        end else begin
          cyc_cnt_s = cyc_cnt_r + LEN_ONE;
          enable_s  = 1'b0;
        end
      end
      DONE: begin
        state_s  = IDLE;
        enable_s = 1'b0;
      end
      default: begin
        state_s  = IDLE;
        enable_s = 1'b0;
      end
    endcase
  end

  // State, latched configuration and registered outputs.
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_r     <= IDLE;
      run_len_r   <= LEN_ZERO;
      pause_len_r <= LEN_ZERO;
      bursts_r    <= BURST_ZERO;
      cyc_cnt_r   <= LEN_ZERO;
      burst_cnt_r <= BURST_ZERO;
      enable_r    <= 1'b0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      aborted_r   <= 1'b0;
      error_r     <= 1'b0;
    end else begin
      state_r     <= state_s;
      run_len_r   <= run_len_s;
      pause_len_r <= pause_len_s;
      bursts_r    <= bursts_s;
      cyc_cnt_r   <= cyc_cnt_s;
      burst_cnt_r <= burst_cnt_s;
      enable_r    <= enable_s;
      busy_r      <= (state_s != IDLE);
      done_r      <= done_s;
      aborted_r   <= aborted_s;
      error_r     <= error_s;
    end
  end

  assign enable_o    = enable_r;
  assign busy_o      = busy_r;
  assign done_o      = done_r;
  assign aborted_o   = aborted_r;
  assign error_o     = error_r;
  assign burst_cnt_o = burst_cnt_r;

endmodule

// File: doc/counter_sequencer.md
COUNTER_SEQUENCER -- requirements
Module: counter_sequencer

Interface
REQ-001 Parameter LEN_BITWIDTH, default 8, width of the run-length and pause-length fields.
REQ-002 Parameter BURST_BITWIDTH, default 4, width of the burst-count field and burst_cnt_o.
REQ-003 clock_i  input  1  single clock; all logic rising-edge triggered.
REQ-004 reset_i  input  1  reset, synchronous, active-high.
REQ-005 start_i  input  1  request a new sequence; sampled only in IDLE.
REQ-006 abort_i  input  1  terminate the current sequence.
REQ-007 run_len_i  input  LEN_BITWIDTH  number of cycles enable_o is high per burst.
REQ-008 pause_len_i  input  LEN_BITWIDTH  number of cycles enable_o is low between bursts.
REQ-009 bursts_i  input  BURST_BITWIDTH  number of bursts in the sequence.
REQ-010 enable_o  output  1  registered enable driving the counter's enable_i.
REQ-011 busy_o  output  1  high in every state other than IDLE.
REQ-012 done_o  output  1  one-cycle pulse on normal completion.
REQ-013 aborted_o  output  1  one-cycle pulse on abort.
REQ-014 error_o  output  1  one-cycle pulse on rejected start.
REQ-015 burst_cnt_o  output  BURST_BITWIDTH  completed bursts of the current or last sequence.

Function
REQ-016 The FSM SHALL have exactly four states: IDLE, RUN, PAUSE, DONE.
REQ-017 Accept: in IDLE with start_i=1, abort_i=0, run_len_i!=0 and bursts_i!=0 -> latch run_len, pause_len and bursts, clear burst_cnt_o, go to RUN.
REQ-018 Reject: in IDLE with start_i=1, abort_i=0 and run_len_i=0 or bursts_i=0 -> error_o=1 next cycle, stay IDLE, no other output changes.
REQ-019 Latency: enable_o SHALL rise on the first clock edge after the accepting edge.
REQ-020 RUN: enable_o SHALL be high for exactly run_len consecutive cycles per burst.
REQ-021 At end of a burst, burst_cnt_o SHALL increment by 1 on the same edge that enable_o falls or the next burst starts.
REQ-022 After a non-final burst with pause_len!=0 -> PAUSE; enable_o low for exactly pause_len cycles, then RUN.
REQ-023 After a non-final burst with pause_len=0 -> RUN directly; enable_o stays high continuously for the next run_len cycles.
REQ-024 After the final burst -> DONE for one cycle with enable_o=0 and done_o=1, then IDLE.
REQ-025 burst_cnt_o SHALL equal bursts in DONE and SHALL hold that value in IDLE until the next accepted start.
REQ-026 Inputs start_i, run_len_i, pause_len_i and bursts_i SHALL be ignored outside IDLE; latched values are not affected.
REQ-027 Abort: abort_i=1 in RUN or PAUSE -> next edge IDLE, enable_o=0, aborted_o=1 for one cycle, done_o stays 0, burst_cnt_o holds.
REQ-028 abort_i in DONE SHALL be ignored; the sequence completes normally.
REQ-029 abort_i and start_i together in IDLE -> no accept, no error, no pulse.
REQ-030 Abort SHALL take priority over the end-of-burst transition on the same cycle.
REQ-031 Internal cycle counters SHALL be LEN_BITWIDTH wide; a length of 2^LEN_BITWIDTH-1 SHALL be supported without wrap.

Reset
REQ-032 reset_i=1 on a clock edge SHALL force IDLE, enable_o=0, busy_o=0, done_o=0, aborted_o=0, error_o=0, burst_cnt_o=0 and clear latched config.
REQ-033 Reset asserted mid-sequence SHALL behave as REQ-032 on the next edge, with no done_o or aborted_o pulse.
REQ-034 start_i while reset_i=1 SHALL be ignored.

Verification
REQ-035 Accept run_len=10, pause_len=5, bursts=2 -> enable_o high 10, low 5, high 10 cycles -> done_o pulse, burst_cnt_o=2; counter advances 20 counts modulo its maximum.
REQ-036 Accept run_len=3, pause_len=0, bursts=3 -> enable_o high 9 contiguous cycles, then done_o pulse, burst_cnt_o=3.
REQ-037 Start with run_len=0 -> error_o one-cycle pulse, busy_o stays 0; start with bursts=0 -> same.
REQ-038 Accept run_len=10, bursts=4; abort at cycle 4 of burst 2 -> enable_o low next edge, aborted_o pulse, burst_cnt_o=1, no done_o.
REQ-039 start_i held high during a sequence -> no restart; one done_o at the end; a new sequence is accepted only if start_i is still high in IDLE.
REQ-040 reset_i during PAUSE -> all outputs at reset values next edge; restart with run_len=1, bursts=1 -> enable_o high exactly one cycle, done_o pulse.
